// File: rtl/sfifo_wr_arb.sv
// Round-robin write arbiter in front of a synchronous FIFO write port.
// Define SFIFO_ARB_BURST_EN to compile in the LOCK state (up to MAX_BURST beats per grant).
module sfifo_wr_arb #(
    parameter int WIDTH     = 8,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ*WIDTH-1:0]      req_data,
    output logic [NREQ-1:0]            gnt,
    input  logic                       wfull,
    output logic                       winc,
    output logic [WIDTH-1:0]           wdata,
    output logic [$clog2(NREQ)-1:0]    owner,
    output logic                       locked
);

    localparam int IW = $clog2(NREQ);

    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   rr_win;
    logic            rr_found;
    logic [NREQ-1:0] gnt_c;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        if (int'(i) == NREQ - 1)
            return '0;
        else
            return i + 1'b1;
    endfunction

    // First requester at or after ptr, wrapping modulo NREQ.
    always_comb begin
        rr_found = 1'b0;
        rr_win   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!rr_found && req[(int'(ptr_q) + k) % NREQ]) begin
                rr_found = 1'b1;
                rr_win   = IW'((int'(ptr_q) + k) % NREQ);
            end
        end
    end

`ifdef SFIFO_ARB_BURST_EN
    localparam int CW = $clog2(MAX_BURST + 1);

    // state | meaning
    // IDLE  | round-robin arbitration every cycle
    // LOCK  | only owner may write, until MAX_BURST beats or owner drops req
    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] own_q, own_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        gnt_c   = '0;
        if (!rst && !wfull) begin
            case (state_q)
                IDLE: begin
                    if (rr_found) begin
                        gnt_c[rr_win] = 1'b1;
                        ptr_d         = next_idx(rr_win);
                        if (MAX_BURST > 1) begin
                            state_d = LOCK;
                            own_d   = rr_win;
                            cnt_d   = CW'(1);
                        end
                    end
                end
                LOCK: begin
                    if (!req[own_q]) begin
                        // bubble cycle: release without granting anyone
                        state_d = IDLE;
                        ptr_d   = next_idx(own_q);
                        own_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        gnt_c[own_q] = 1'b1;
                        if (cnt_q == CW'(MAX_BURST - 1)) begin
                            state_d = IDLE;
                            ptr_d   = next_idx(own_q);
                            own_d   = '0;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            own_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            cnt_q   <= cnt_d;
        end
    end

    assign locked = (state_q == LOCK);
    assign owner  = own_q;
`else
    always_comb begin
        ptr_d = ptr_q;
        gnt_c = '0;
        if (!rst && !wfull && rr_found) begin
            gnt_c[rr_win] = 1'b1;
            ptr_d         = next_idx(rr_win);
        end
    end

    assign locked = 1'b0;
    assign owner  = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr_q <= '0;
        else
            ptr_q <= ptr_d;
    end

    assign gnt  = gnt_c;
    assign winc = |(req & gnt_c);

    always_comb begin
        wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_c[i])
                wdata = req_data[i*WIDTH +: WIDTH];
        end
    end

endmodule

// File: tb/tb_sfifo_wr_arb.sv
// Scoreboard bench for sfifo_wr_arb; expected beats are queued by the stimulus, popped by the monitor.
module tb_sfifo_wr_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic        wfull;
    logic        wfull_drv;
    logic        winc;
    logic [7:0]  wdata;
    logic [1:0]  owner;
    logic        locked;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] g;
        logic [7:0] d;
    } beat_t;
    beat_t exp_q[$];

    bit         fifo_mode = 1'b0;
    logic [7:0] fmem[16];
    int         fcnt;

    logic [7:0] bytes[4][8];
    int         idx[4];
    logic [7:0] log_b[16];
    logic [3:0] g_last;

    always #5 clk = ~clk;

    assign wfull = fifo_mode ? (fcnt >= 16) : wfull_drv;

    sfifo_wr_arb #(.WIDTH(8), .NREQ(4), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
        .wfull(wfull), .winc(winc), .wdata(wdata), .owner(owner), .locked(locked)
    );

    // Behavioural FIFO sink, reader idle.
    always @(posedge clk or posedge rst) begin
        if (rst)
            fcnt <= 0;
        else if (winc && fcnt < 16) begin
            fmem[fcnt] <= wdata;
            fcnt       <= fcnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] g, input logic [7:0] d, input int n);
        beat_t b;
        b.g = g;
        b.d = d;
        for (int i = 0; i < n; i++) exp_q.push_back(b);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string name);
        @(negedge clk);
        chk({name, "_gnt"},  {28'd0, gnt}, 32'd0);
        chk({name, "_winc"}, {31'd0, winc}, 32'd0);
    endtask

    // Monitor: every write the DUT issues must be the next expected beat.
    always @(negedge clk) begin
        if (!rst && winc) begin
            checks++;
            if (wfull) begin
                errors++;
                $display("FAIL winc_while_full actual=1 required=0");
            end
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write gnt=%b wdata=%0h required=no write", gnt, wdata);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                if (gnt !== e.g || wdata !== e.d) begin
                    errors++;
                    $display("FAIL beat actual gnt=%b wdata=%0h required gnt=%b wdata=%0h",
                             gnt, wdata, e.g, e.d);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req       = 4'b1111;
        req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
        wfull_drv = 1'b0;
        @(negedge clk);
        chk("rst_gnt",    {28'd0, gnt}, 32'd0);
        chk("rst_winc",   {31'd0, winc}, 32'd0);
        chk("rst_wdata",  {24'd0, wdata}, 32'd0);
        chk("rst_locked", {31'd0, locked}, 32'd0);
        chk("rst_owner",  {30'd0, owner}, 32'd0);

`ifndef SFIFO_ARB_BURST_EN
        // Single-beat round-robin from ptr=0.
        push(4'b0001, 8'h11, 1); push(4'b0010, 8'h22, 1); push(4'b0100, 8'h33, 1);
        push(4'b1000, 8'h44, 1); push(4'b0001, 8'h11, 1);
        tick(); rst = 1'b0;
        @(negedge clk);
        chk("nb_locked", {31'd0, locked}, 32'd0);
        repeat (5) tick();
        // ptr=1: full blocks everything, then 0101 searches 1,2 -> 2 then 3,0 -> 0.
        req = 4'b0101; wfull_drv = 1'b1;
        chk_idle("full0"); tick();
        chk_idle("full1"); tick();
        wfull_drv = 1'b0;
        push(4'b0100, 8'h33, 1); push(4'b0001, 8'h11, 1);
        repeat (2) tick();
        req = 4'b1000;
        push(4'b1000, 8'h44, 3);
        repeat (3) tick();
        // ptr=0: two grants leave ptr=2, reset must return it to 0.
        req = 4'b1111;
        push(4'b0001, 8'h11, 1); push(4'b0010, 8'h22, 1);
        repeat (2) tick();
        rst = 1'b1;
        chk_idle("midrst");
        chk("midrst_wdata", {24'd0, wdata}, 32'd0);
        tick();
        rst = 1'b0; req = 4'b0110;
        push(4'b0010, 8'h22, 1);
        tick();
        req = 4'b0000;
        tick();
`else
        // Two requesters, 4-beat bursts each.
        tick(); rst = 1'b0; req = 4'b0011;
        push(4'b0001, 8'h11, 4); push(4'b0010, 8'h22, 4);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 0) chk("b_first_unlocked", {31'd0, locked}, 32'd0);
            if (c == 1) begin
                chk("b_locked0", {31'd0, locked}, 32'd1);
                chk("b_owner0",  {30'd0, owner}, 32'd0);
            end
            if (c == 5) chk("b_owner1", {30'd0, owner}, 32'd1);
            tick();
        end
        // ptr=2: requester 2 locked with count=2, then stall 3 cycles.
        req = 4'b0100;
        push(4'b0100, 8'h33, 2);
        repeat (2) tick();
        wfull_drv = 1'b1;
        for (int c = 0; c < 3; c++) begin
            chk_idle("stall");
            chk("stall_locked", {31'd0, locked}, 32'd1);
            chk("stall_owner",  {30'd0, owner}, 32'd2);
            tick();
        end
        wfull_drv = 1'b0;
        push(4'b0100, 8'h33, 2);
        repeat (2) tick();
        // Unlocked with ptr=3: 0110 searches 3,0,1 -> 1.
        req = 4'b0110;
        push(4'b0010, 8'h22, 1);
        @(negedge clk);
        chk("unlock_after_max", {31'd0, locked}, 32'd0);
        tick();
        req = 4'b1010;
        push(4'b0010, 8'h22, 1);
        tick();
        // Owner 1 drops: one bubble, then requester 3.
        req = 4'b1000;
        chk_idle("bubble");
        tick();
        push(4'b1000, 8'h44, 1);
        tick();
        req = 4'b0000;
        repeat (2) tick();
        // Reset at count=3.
        req = 4'b0100;
        push(4'b0100, 8'h33, 3);
        repeat (3) tick();
        rst = 1'b1;
        chk_idle("midrst");
        chk("midrst_locked", {31'd0, locked}, 32'd0);
        chk("midrst_owner",  {30'd0, owner}, 32'd0);
        tick();
        rst = 1'b0; req = 4'b1000;
        push(4'b1000, 8'h44, 1);
        tick();
        req = 4'b0000;
        repeat (2) tick();
`endif

        // FIFO of depth 16: four requesters, 8 bytes each.
        rst = 1'b1; req = 4'b0000;
        tick(); tick();
        fifo_mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idx[i] = 0;
            for (int k = 0; k < 8; k++) bytes[i][k] = 8'($urandom_range(0, 255));
        end
        for (int j = 0; j < 16; j++) begin
`ifdef SFIFO_ARB_BURST_EN
            log_b[j] = bytes[j / 4][j % 4];
            push(4'b0001 << (j / 4), log_b[j], 1);
`else
            log_b[j] = bytes[j % 4][j / 4];
            push(4'b0001 << (j % 4), log_b[j], 1);
`endif
        end
        g_last = 4'b0000;
        rst = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            for (int i = 0; i < 4; i++) begin
                if (g_last[i]) idx[i]++;
                req[i] = (idx[i] < 8);
                req_data[i*8 +: 8] = bytes[i][idx[i] % 8];
            end
            @(negedge clk);
            g_last = winc ? gnt : 4'b0000;
        end
        tick();
        req = 4'b0000;
        chk("fifo_writes", fcnt, 32'd16);
        for (int j = 0; j < 16; j++) chk("fifo_order", {24'd0, fmem[j]}, {24'd0, log_b[j]});
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sfifo_wr_arb.md
SFIFO_WR_ARB -- requirements
Module: sfifo_wr_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width of each requester and of the FIFO write port.
REQ-002 SHALL have parameter NREQ, default 4, range 2..8: number of requesters.
REQ-003 SHALL have parameter MAX_BURST, default 4, range 1..16: maximum consecutive beats per grant (burst mode only).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port req  input  NREQ  per-requester write request; bit i belongs to requester i.
REQ-007 SHALL have port req_data  input  NREQ*WIDTH  requester write data; slice [i*WIDTH +: WIDTH] belongs to requester i.
REQ-008 SHALL have port gnt  output  NREQ  one-hot or zero; bit i high means requester i's beat is written this cycle.
REQ-009 SHALL have port wfull  input  1  FIFO full flag.
REQ-010 SHALL have port winc  output  1  FIFO write enable.
REQ-011 SHALL have port wdata  output  WIDTH  FIFO write data.
REQ-012 SHALL have port owner  output  $clog2(NREQ)  index of the requester holding the lock; 0 when idle.
REQ-013 SHALL have port locked  output  1  high while in LOCK state.

Function
REQ-014 SHALL compute gnt, winc and wdata combinationally from req, wfull and registered state, with zero-cycle latency.
REQ-015 SHALL drive gnt all-zero and winc low whenever wfull is high.
REQ-016 SHALL define accept as winc high; winc SHALL equal OR of (req AND gnt).
REQ-017 SHALL drive wdata with the granted requester's slice when winc is high, and all-zero otherwise.
REQ-018 SHALL keep a round-robin pointer ptr; in IDLE, the grant goes to the first requesting index found searching ptr, ptr+1, ... modulo NREQ.
REQ-019 SHALL set ptr to (winner+1) mod NREQ on every accept made in IDLE state.
REQ-020 SHALL implement FSM states IDLE and LOCK (LOCK exists only with burst mode enabled).
REQ-021 IDLE->LOCK SHALL occur on accept when MAX_BURST>1: owner=winner, beat count=1.
REQ-022 In LOCK, only owner SHALL be eligible for grant; other requests are ignored.
REQ-023 In LOCK with wfull high, the block SHALL stall: state, owner and count are unchanged, with no grant.
REQ-024 In LOCK with owner req low, the block SHALL return to IDLE with no grant that cycle (one bubble cycle) and set ptr=(owner+1) mod NREQ.
REQ-025 In LOCK, an accept that brings count to MAX_BURST SHALL return the block to IDLE and set ptr=(owner+1) mod NREQ; otherwise count SHALL increment.
REQ-026 Simultaneous requests with no lock SHALL be resolved by round-robin only; no requester SHALL wait more than NREQ-1 grants (or bursts).

Reset
REQ-027 Asserting rst at any time, including mid-burst, SHALL immediately force state=IDLE, ptr=0, owner=0, count=0, locked=0.
REQ-028 While rst is high, the block SHALL hold gnt=0, winc=0 and wdata=0 regardless of req.
REQ-029 After rst deasserts, the first grant SHALL follow REQ-018 with ptr=0.

Configuration
REQ-030 Macro SFIFO_ARB_BURST_EN defined: LOCK state, count and MAX_BURST behaviour SHALL be compiled in per REQ-020..REQ-025.
REQ-031 Macro SFIFO_ARB_BURST_EN undefined: the block SHALL stay in IDLE, re-arbitrate every cycle (single-beat round-robin), tie locked to 0 and owner to 0, and ignore MAX_BURST.

Verification
REQ-032 Reset, then req=4'b1111, wfull=0, burst undefined -> gnt sequence 0001,0010,0100,1000,0001 on consecutive cycles; wdata matches each granted slice.
REQ-033 Burst defined, MAX_BURST=4, req=4'b0011 held -> requester 0 granted 4 cycles, locked high, then requester 1 granted 4 cycles.
REQ-034 Burst defined, requester 2 locked with count=2, wfull pulsed high 3 cycles -> gnt=0 and winc=0 for those cycles; after release, 2 more beats to requester 2, then unlock.
REQ-035 Burst defined, requester 1 locked, req[1] drops after 2 beats while req[3]=1 -> one bubble cycle (gnt=0), then requester 3 granted.
REQ-036 Connected to a WIDTH=8, DEPTH=16 sync FIFO, 4 requesters each writing 8 random bytes, reader idle -> exactly 16 writes, winc never high while wfull high; after draining, read order matches the grant log.
REQ-037 rst asserted mid-burst (count=3) -> gnt, winc, locked drop to 0 in the same cycle; after release with req=4'b1000, first grant goes to requester 3 (search from ptr=0).
